// File: rtl/vedic_pkg.sv
// Shared types and step encoding for the time-shared Vedic multiplier controller.
package vedic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int STEP_W = 2;

  // Step order fixes which operand halves are paired and how far the result shifts.
  localparam logic [STEP_W-1:0] STEP_LL = 2'd0;
  localparam logic [STEP_W-1:0] STEP_HL = 2'd1;
  localparam logic [STEP_W-1:0] STEP_LH = 2'd2;
  localparam logic [STEP_W-1:0] STEP_HH = 2'd3;

endpackage

// File: rtl/vedic_pp_mult.sv
// Combinational HALFxHALF Urdhva-Tiryagbhyam (crosswise) multiplier: each product
// column is the popcount of its crosswise bit pairs plus the carry from the column below.
module vedic_pp_mult #(
  parameter int HALF = 8
) (
  input  logic [HALF-1:0]   a,
  input  logic [HALF-1:0]   b,
  output logic [2*HALF-1:0] p
);

  localparam int COLS = 2 * HALF;
  localparam int CW   = $clog2(COLS) + 2;

  logic [CW-1:0] cnt   [COLS][HALF+1];
  logic [CW-1:0] col   [COLS];
  logic [CW-1:0] carry [COLS];

  assign carry[0] = '0;

  for (genvar k = 0; k < COLS; k++) begin : g_col
    assign cnt[k][0] = '0;
    for (genvar i = 0; i < HALF; i++) begin : g_term
      if ((k - i >= 0) && (k - i < HALF)) begin : g_pair
        assign cnt[k][i+1] = cnt[k][i] + CW'(a[i] & b[k-i]);
      end else begin : g_none
        assign cnt[k][i+1] = cnt[k][i];
      end
    end

    assign col[k] = cnt[k][HALF] + carry[k];

    if (k < COLS - 1) begin : g_carry
      assign p[k]       = col[k][0];
      assign carry[k+1] = col[k] >> 1;
    end else begin : g_top
      // The top column of a HALFxHALF product can only sum to 0 or 1.
      assign p[k] = |col[k];
    end
  end

endmodule

// File: rtl/vedic_mult16_seq_ctrl.sv
// Sequencing controller: reuses one HALFxHALF Vedic unit and one 2*WIDTH adder over
// four steps, with valid/ready handshakes on the operand and result sides.
module vedic_mult16_seq_ctrl
  import vedic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int HALF = WIDTH / 2;
  localparam int PW   = 2 * WIDTH;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [PW-1:0]       acc_q, acc_d;
  logic [PW-1:0]       product_q, product_d;
  logic                out_valid_q, out_valid_d;

  logic [HALF-1:0]     a_half;
  logic [HALF-1:0]     b_half;
  logic [2*HALF-1:0]   pp;
  logic [PW-1:0]       pp_ext;
  logic [PW-1:0]       addend;
  logic [PW-1:0]       acc_sum;

  always_comb begin
    a_half = a_q[HALF-1:0];
    b_half = b_q[HALF-1:0];
    unique case (step_q)
      STEP_LL: begin a_half = a_q[HALF-1:0];     b_half = b_q[HALF-1:0];     end
      STEP_HL: begin a_half = a_q[WIDTH-1:HALF]; b_half = b_q[HALF-1:0];     end
      STEP_LH: begin a_half = a_q[HALF-1:0];     b_half = b_q[WIDTH-1:HALF]; end
      STEP_HH: begin a_half = a_q[WIDTH-1:HALF]; b_half = b_q[WIDTH-1:HALF]; end
      default: begin a_half = a_q[HALF-1:0];     b_half = b_q[HALF-1:0];     end
    endcase
  end

  vedic_pp_mult #(
    .HALF (HALF)
  ) u_pp_mult (
    .a (a_half),
    .b (b_half),
    .p (pp)
  );

  assign pp_ext = {{(PW-2*HALF){1'b0}}, pp};

  // Full-width shift and add; the final sum never exceeds (2^WIDTH-1)^2.
  always_comb begin
    addend = pp_ext;
    unique case (step_q)
      STEP_LL: addend = pp_ext;
      STEP_HL: addend = pp_ext << HALF;
      STEP_LH: addend = pp_ext << HALF;
      STEP_HH: addend = pp_ext << WIDTH;
      default: addend = pp_ext;
    endcase
  end

  assign acc_sum = acc_q + addend;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          step_d  = STEP_LL;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d  = acc_sum;
        step_d = step_q + 2'd1;
        if (step_q == STEP_HH) begin
          product_d   = acc_sum;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= STEP_LL;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == MUL) || (state_q == DONE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_vedic_mult16_seq_ctrl.sv
// Randomized self-checking bench for vedic_mult16_seq_ctrl against a plain a*b reference.
module tb_vedic_mult16_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vedic_mult16_seq_ctrl #(
    .WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  function automatic logic [31:0] ref_product(input logic [15:0] x, input logic [15:0] y);
    longint unsigned r;
    r = longint'(x) * longint'(y);
    return r[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full transaction: accept, four MUL steps with noisy inputs, optional backpressure, handoff.
  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input int hold);
    logic [31:0] exp;
    int lat;
    bit seen;
    exp = ref_product(x, y);
    @(negedge clk);
    checkOutput("in_ready_idle", in_ready, 1);
    a = x;
    b = y;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    seen = 1'b0;
    lat = 0;
    @(posedge clk);
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        lat = c;
      end else begin
        checkOutput("busy_mul", {busy, in_ready}, 2'b10);
        a = 16'($urandom);
        b = 16'($urandom);
        in_valid = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b0;
    if (!seen) begin
      checkOutput("timeout", 0, 1);
      return;
    end
    checkOutput("latency", lat, 4);
    checkOutput("product", product, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("hold_flags", {out_valid, in_ready, busy}, 3'b101);
      checkOutput("hold_product", product, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("handoff_flags", {out_valid, in_ready, busy}, 3'b010);
    checkOutput("product_retained", product, exp);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_product", product, 0);
    checkOutput("reset_flags", {out_valid, in_ready, busy}, 3'b010);
    rst_n = 1'b1;

    applyStimulus(16'h1234, 16'h5678, 0);
    checkOutput("known_1234x5678", product, 32'h06260060);
    applyStimulus(16'hFFFF, 16'hFFFF, 1);
    checkOutput("known_ffff_sq", product, 32'hFFFE0001);
    applyStimulus(16'h0000, 16'hBEEF, 0);
    checkOutput("known_zero", product, 0);
    applyStimulus(16'h00FF, 16'h0100, 0);
    checkOutput("known_latched", product, 32'h0000FF00);
    applyStimulus(16'hA5C3, 16'h3C5A, 3);

    // Abort during step 2: nothing partial may leak out.
    @(negedge clk);
    a = 16'h1234;
    b = 16'h5678;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_product", product, 0);
    checkOutput("midreset_flags", {out_valid, in_ready, busy}, 3'b010);
    @(negedge clk);
    checkOutput("inreset_flags", {out_valid, in_ready, busy}, 3'b010);
    out_ready = 1'b0;
    rst_n = 1'b1;
    applyStimulus(16'h4321, 16'h8765, 0);

    for (int t = 0; t < 10; t++) begin
      applyStimulus(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
